ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Controller between the `ps2_keyboard` receive FIFO and the display/consumer logic. It pops scan-code bytes from the FIFO with the `nextdata_n` handshake and folds the `E0` (extended) and `F0` (break) prefixes into single key events. It also tracks the shift/ctrl modifiers and counts key presses. Consumers see one valid/ready event stream instead of raw bytes.

## Interface
Parameters:
- `CNT_W`, default 8: width of the key-press counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, same as `ps2_keyboard.clk`
- `rst`  in  1  asynchronous active-high reset
- `ps2_ready`  in  1  FIFO non-empty (`ps2_keyboard.ready`)
- `ps2_byte`  in  8  FIFO head byte (`ps2_keyboard.data`)
- `ps2_overflow`  in  1  FIFO overflow (`ps2_keyboard.overflow`)
- `nextdata_n`  out  1  active-low one-cycle pop strobe to the FIFO
- `evt_valid`  out  1  key event available
- `evt_ready`  in  1  consumer accepts event
- `evt_code`  out  8  scan code without prefixes
- `evt_ext`  out  1  code was `E0`-prefixed
- `evt_break`  out  1  1 = key release, 0 = key press
- `shift_flag`  out  1  left or right shift held
- `ctrl_flag`  out  1  left or right ctrl held
- `press_cnt`  out  CNT_W  number of press events emitted
- `ovf_err`  out  1  sticky FIFO-overflow indicator

## Operation
- FSM states: IDLE, POP, DECODE, EMIT. All outputs are registered.
- IDLE: if `ps2_ready`=1, latch `ps2_byte` into `byte_r`, drive `nextdata_n`=0, go to POP. Otherwise stay.
- POP: drive `nextdata_n`=1, go to DECODE. This cycle absorbs the FIFO pointer update, so stale `ready` cannot cause a double pop.
- DECODE, by byte value:
  - `F0`: set `brk_pend`, go to IDLE.
  - `E0`: set `ext_pend`, go to IDLE.
  - Any other byte: build the event {code=`byte_r`, ext=`ext_pend`, break=`brk_pend`}, clear both pending flags, update modifiers. Go to EMIT, or to IDLE if the event is suppressed (see Configuration).
- EMIT: `evt_valid`=1 with `evt_code`/`evt_ext`/`evt_break` held stable until `evt_valid`&`evt_ready` is sampled high. Then drop `evt_valid` and go to IDLE.
- No pops occur during EMIT; unread bytes stay in the FIFO, which is the backpressure path.
- Modifier register updates (set on make, clear on break; no event is required to be accepted):
  - `12` → lshift; `59` → rshift.
  - non-ext `14` → lctrl; ext `14` → rctrl.
  - `shift_flag` = lshift|rshift; `ctrl_flag` = lctrl|rctrl.
- `press_cnt` increments by 1 when a make event enters EMIT. It wraps from all-ones to 0.
- `ovf_err` is set when `ps2_overflow`=1 in any cycle and stays set until reset.
- A prefix followed by a further prefix accumulates: `E0 F0 xx` gives ext=1, break=1.

## Timing
- Reset values:
  - `nextdata_n`=1.
  - `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_break`=0.
  - Both modifier flags=0, `press_cnt`=0, `ovf_err`=0.
  - FSM in IDLE, pending flags and held-key register cleared.
- A byte seen in IDLE at edge T gives: `nextdata_n` low in cycle T+1, high in T+2, and `evt_valid` high from T+3.
- Each byte consumes at least 3 cycles (IDLE→POP→DECODE); exactly one pop per byte.
- With `evt_ready` tied high, `evt_valid` is high for exactly 1 cycle. The next byte can be latched the cycle after `evt_valid` falls.
- Reset asserted mid-sequence:
  - Any in-flight byte and prefix state are discarded; `nextdata_n` returns to 1 immediately.
  - The FIFO is reset by the same `rst` via `clrn`.
- `ps2_ready` dropping while in POP or DECODE has no effect.

## Configuration
- `PS2SEQ_TYPEMATIC_FILTER_EN` defined:
  - A held-key register {valid, ext, code} records the last make event.
  - A make event whose ext/code matches the held key while valid is suppressed: no EMIT, no `press_cnt` increment, modifiers unchanged.
  - A break of the held key clears valid. A make of a different key replaces it.
  - Break events are never suppressed.
- Not defined: no held-key register. Every make, including typematic repeats, is emitted and counted.

## Test plan
- FIFO bytes `1C`, `F0`, `1C`, with `evt_ready`=1:
  - Exactly 3 `nextdata_n` pulses.
  - Events {1C, ext0, brk0} then {1C, ext0, brk1}.
  - `press_cnt`=1.
- Bytes `E0 14 E0 F0 14`:
  - `ctrl_flag` rises after the first event and falls after the second.
  - Events show ext=1, break=0 then ext=1, break=1.
- `evt_ready`=0 for 20 cycles with bytes `12` and `1A` queued:
  - `evt_valid` and fields stay stable.
  - No second pop until the handshake; `shift_flag`=1 throughout.
- Bytes `1C 1C 1C F0 1C`:
  - With the filter: 2 events, `press_cnt`=1.
  - Without the filter: 4 events, `press_cnt`=3.
- Wrap and overflow:
  - Starting from `press_cnt`=FF (CNT_W=8), one more make gives `press_cnt`=00.
  - A 1-cycle `ps2_overflow` pulse leaves `ovf_err`=1 until `rst`.
- Assert `rst` during POP after an `E0`:
  - All outputs return to reset values.
  - A following byte `14` yields ext=0.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// Pops scan-code bytes from the ps2_keyboard FIFO, folds the E0 (extended)
// and F0 (break) prefixes into single key events, tracks shift/ctrl, counts
// key presses and exposes the result as a valid/ready event stream.
//
// Optional build macro: PS2SEQ_TYPEMATIC_FILTER_EN
//   When defined, a held-key register suppresses typematic repeats of the
//   last pressed key. When undefined, every make event is emitted.
module ps2_key_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_ready,
  input  logic [7:0]       ps2_byte,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             shift_flag,
  output logic             ctrl_flag,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_DECODE,
    S_EMIT
  } state_t;

  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_byte;
  logic       r_brk_pend;
  logic       r_ext_pend;

  logic       r_lshift;
  logic       r_rshift;
  logic       r_lctrl;
  logic       r_rctrl;
  logic       w_lshift_nxt;
  logic       w_rshift_nxt;
  logic       w_lctrl_nxt;
  logic       w_rctrl_nxt;

  logic       w_is_brk;
  logic       w_is_ext;
  logic       w_is_key;
  logic       w_suppress;
  logic       w_key_upd;

  assign w_is_brk  = (r_byte == BYTE_BRK);
  assign w_is_ext  = (r_byte == BYTE_EXT);
  assign w_is_key  = !w_is_brk && !w_is_ext;
  // A non-prefix byte in DECODE that is not filtered updates all key state.
  assign w_key_upd = (r_state == S_DECODE) && w_is_key && !w_suppress;

`ifdef PS2SEQ_TYPEMATIC_FILTER_EN
  logic       r_held_valid;
  logic       r_held_ext;
  logic [7:0] r_held_code;
  logic       w_held_match;

  assign w_held_match = r_held_valid && (r_held_ext == r_ext_pend) &&
                        (r_held_code == r_byte);
  // Only a repeated make of the held key is dropped; breaks always pass.
  assign w_suppress   = w_held_match && !r_brk_pend;

  // Held-key register: a make records the key, a break of that key releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held_valid <= 1'b0;
      r_held_ext   <= 1'b0;
      r_held_code  <= 8'h00;
    end else if (w_key_upd) begin
      if (!r_brk_pend) begin
        r_held_valid <= 1'b1;
        r_held_ext   <= r_ext_pend;
        r_held_code  <= r_byte;
      end else if (w_held_match) begin
        r_held_valid <= 1'b0;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is always assigned with <=, so every flop in the
    // design samples the pre-edge values no matter how blocks are ordered.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default first assignment covers every path through the case,
    // so no latch is inferred for w_state_nxt.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (ps2_ready) w_state_nxt = S_POP;
      S_POP:    w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_is_key && !w_suppress) ? S_EMIT : S_IDLE;
      S_EMIT:   if (evt_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: pop strobe, byte capture, prefix folding, event fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nextdata_n <= 1'b1;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_ext    <= 1'b0;
      evt_break  <= 1'b0;
      press_cnt  <= '0;
      r_byte     <= 8'h00;
      r_brk_pend <= 1'b0;
      r_ext_pend <= 1'b0;
    end else begin
      nextdata_n <= 1'b1;
      evt_valid  <= (w_state_nxt == S_EMIT);
      case (r_state)
        S_IDLE: begin
          if (ps2_ready) begin
            r_byte     <= ps2_byte;
            nextdata_n <= 1'b0;
          end
        end
        S_DECODE: begin
          if (w_is_brk) begin
            r_brk_pend <= 1'b1;
          end else if (w_is_ext) begin
            r_ext_pend <= 1'b1;
          end else begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
            if (!w_suppress) begin
              evt_code  <= r_byte;
              evt_ext   <= r_ext_pend;
              evt_break <= r_brk_pend;
              if (!r_brk_pend) press_cnt <= press_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next modifier values: set on make, clear on break of the matching key.
  always_comb begin
    w_lshift_nxt = r_lshift;
    w_rshift_nxt = r_rshift;
    w_lctrl_nxt  = r_lctrl;
    w_rctrl_nxt  = r_rctrl;
    if (w_key_upd) begin
      case (r_byte)
        KEY_LSHIFT: w_lshift_nxt = !r_brk_pend;
        KEY_RSHIFT: w_rshift_nxt = !r_brk_pend;
        KEY_CTRL: begin
          if (r_ext_pend) w_rctrl_nxt = !r_brk_pend;
          else            w_lctrl_nxt = !r_brk_pend;
        end
        default: ;
      endcase
    end
  end

  // Modifier registers and their registered OR-ed flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      r_lctrl    <= 1'b0;
      r_rctrl    <= 1'b0;
      shift_flag <= 1'b0;
      ctrl_flag  <= 1'b0;
    end else begin
      r_lshift   <= w_lshift_nxt;
      r_rshift   <= w_rshift_nxt;
      r_lctrl    <= w_lctrl_nxt;
      r_rctrl    <= w_rctrl_nxt;
      shift_flag <= w_lshift_nxt | w_rshift_nxt;
      ctrl_flag  <= w_lctrl_nxt | w_rctrl_nxt;
    end
  end

  // Sticky FIFO overflow indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ovf_err <= 1'b0;
    else if (ps2_overflow) ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer. A behavioural FIFO feeds bytes,
// expected events go into a scoreboard queue as bytes are pushed, and a
// monitor pops and compares them on every accepted event.
module tb_ps2_key_sequencer;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       shift;
    logic       ctrl;
  } evt_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ps2_ready = 1'b0;
  logic [7:0]       ps2_byte = 8'h00;
  logic             ps2_overflow = 1'b0;
  logic             nextdata_n;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic             shift_flag;
  logic             ctrl_flag;
  logic [CNT_W-1:0] press_cnt;
  logic             ovf_err;

  logic [7:0] fifo[$];
  evt_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pop_cnt  = 0;
  logic [7:0] exp_cnt  = 8'h00;

  ps2_key_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_ready    (ps2_ready),
    .ps2_byte     (ps2_byte),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .shift_flag   (shift_flag),
    .ctrl_flag    (ctrl_flag),
    .press_cnt    (press_cnt),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk,
                            input logic shift, input logic ctrl);
    evt_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.shift = shift; e.ctrl = ctrl;
    sb.push_back(e);
    if (!brk) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check(tag, 32'(fifo.size() + sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_nextdata_n", {31'd0, nextdata_n}, 32'd1);
    check("rst_evt_valid",  {31'd0, evt_valid},  32'd0);
    check("rst_evt_code",   {24'd0, evt_code},   32'd0);
    check("rst_evt_ext",    {31'd0, evt_ext},    32'd0);
    check("rst_evt_break",  {31'd0, evt_break},  32'd0);
    check("rst_shift",      {31'd0, shift_flag}, 32'd0);
    check("rst_ctrl",       {31'd0, ctrl_flag},  32'd0);
    check("rst_press_cnt",  {24'd0, press_cnt},  32'd0);
    check("rst_ovf_err",    {31'd0, ovf_err},    32'd0);
  endtask

  // FIFO model: pops on a sampled low nextdata_n, head/ready refreshed off-edge.
  initial begin : fifo_model
    logic       do_pop;
    logic [7:0] dropped;
    forever begin
      @(posedge clk);
      do_pop = !nextdata_n;
      #1;
      if (do_pop) begin
        pop_cnt++;
        if (fifo.size() > 0) dropped = fifo.pop_front();
      end
      ps2_ready = (fifo.size() > 0);
      ps2_byte  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      @(negedge clk);
      #1;
      ps2_ready = (fifo.size() > 0);
      ps2_byte  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Scoreboard monitor: an event is consumed when valid and ready meet.
  initial begin : monitor
    evt_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && evt_valid && evt_ready) begin
        if (sb.size() == 0) begin
          check("evt_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("evt_code",  {24'd0, evt_code},   {24'd0, e.code});
          check("evt_ext",   {31'd0, evt_ext},    {31'd0, e.ext});
          check("evt_break", {31'd0, evt_break},  {31'd0, e.brk});
          check("evt_shift", {31'd0, shift_flag}, {31'd0, e.shift});
          check("evt_ctrl",  {31'd0, ctrl_flag},  {31'd0, e.ctrl});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int pops0;
    int nlow;
    int n;
    logic [7:0] key;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Make/break of 1C with latency checks on the first byte.
    pops0 = pop_cnt;
    push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_pop_low",  {31'd0, nextdata_n}, 32'd0);
    @(negedge clk);
    check("lat_pop_high", {31'd0, nextdata_n}, 32'd1);
    check("lat_no_valid", {31'd0, evt_valid},  32'd0);
    @(negedge clk);
    check("lat_valid",    {31'd0, evt_valid},  32'd1);
    @(negedge clk);
    check("lat_one_cyc",  {31'd0, evt_valid},  32'd0);
    push_byte(8'hF0); push_byte(8'h1C); expect_evt(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("t1_drain", 200);
    check("t1_pops", 32'(pop_cnt - pops0), 32'd3);
    check("t1_press_cnt", {24'd0, press_cnt}, 32'd1);

    // Extended right ctrl make then break.
    push_byte(8'hE0); push_byte(8'h14);
    expect_evt(8'h14, 1'b1, 1'b0, 1'b0, 1'b1);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h14);
    expect_evt(8'h14, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain("t2_drain", 200);
    check("t2_ctrl_after", {31'd0, ctrl_flag}, 32'd0);

    // Backpressure: consumer stalls with two bytes queued.
    evt_ready = 1'b0;
    push_byte(8'h12); expect_evt(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    push_byte(8'h1A); expect_evt(8'h1A, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!evt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_valid_up", {31'd0, evt_valid}, 32'd1);
    pops0 = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, evt_valid},  32'd1);
      check("t3_hold_code",  {24'd0, evt_code},   32'h12);
      check("t3_hold_shift", {31'd0, shift_flag}, 32'd1);
      check("t3_no_pop",     32'(pop_cnt - pops0), 32'd0);
    end
    evt_ready = 1'b1;
    push_byte(8'hF0); push_byte(8'h12); expect_evt(8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("t3_drain", 300);
    check("t3_shift_after", {31'd0, shift_flag}, 32'd0);

    // Typematic repeats.
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    push_byte(8'hF0); push_byte(8'h1C);
`ifdef PS2SEQ_TYPEMATIC_FILTER_EN
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    expect_evt(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("t4_drain", 300);
    check("t4_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});

    // Counter wrap: alternate keys until the count reaches FF, then one more.
    key = 8'h1B;
    while (exp_cnt != 8'hFF) begin
      push_byte(key); expect_evt(key, 1'b0, 1'b0, 1'b0, 1'b0);
      key = (key == 8'h1B) ? 8'h1C : 8'h1B;
    end
    wait_drain("t5_drain", 3000);
    check("t5_cnt_ff", {24'd0, press_cnt}, 32'hFF);
    push_byte(8'h23); expect_evt(8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain("t5_drain2", 100);
    check("t5_cnt_wrap", {24'd0, press_cnt}, 32'h00);

    // Sticky overflow.
    check("ovf_before", {31'd0, ovf_err}, 32'd0);
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    repeat (5) @(negedge clk);
    check("ovf_sticky", {31'd0, ovf_err}, 32'd1);

    // Reset during the POP of a byte following E0.
    push_byte(8'hE0); push_byte(8'h14);
    nlow = 0;
    n = 0;
    while (nlow < 2 && n < 50) begin
      @(negedge clk);
      n++;
      if (!nextdata_n) nlow++;
    end
    check("t6_reach_pop", 32'(nlow), 32'd2);
    check("t6_ovf_held", {31'd0, ovf_err}, 32'd1);
    rst = 1'b1;
    fifo.delete();
    sb.delete();
    exp_cnt = 8'h00;
    #1;
    check("t6_nextdata_async", {31'd0, nextdata_n}, 32'd1);
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    push_byte(8'h14); expect_evt(8'h14, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("t6_drain", 100);
    check("t6_press_cnt", {24'd0, press_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
